count_snapshot: RTL and testbench
=================================

# count_snapshot

Downstream consumer of the 4-bit free-running counter: samples `counter_out` every cycle, detects 15→0 wrap-arounds, and keeps a 4-bit wrap count extending the counter to an 8-bit timestamp. On a `capture` request it pushes `{wrap_cnt, count}` into a small show-ahead FIFO drained through a valid/ready handshake. It gives the rest of the design timestamped event snapshots without stalling the counter.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clock` input 1: system clock, rising-edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `count_in` input 4: counter value, wired to the counter's `counter_out`.
- `capture` input 1: snapshot request, sampled each rising edge.
- `snap_data` output 8: head entry, `{wrap[3:0], count[3:0]}`; valid only while `snap_valid`=1.
- `snap_valid` output 1: FIFO non-empty.
- `snap_ready` input 1: consumer accepts head this cycle.
- `full` output 1: FIFO holds `DEPTH` entries.
- `wrap_pulse` output 1: one-cycle pulse, registered, after a detected wrap.
- `wrap_cnt` output 4: current wrap count.
- `ovf` output 1: present only with `SNAP_OVF_EN` (see Configuration).

## Operation
- `prev_count` register holds last cycle's `count_in`; reset value 4'h0.
- Wrap detect (combinational): `wrap_det` = (`prev_count`==4'hF) && (`count_in`==4'h0). Other transitions, including 4'hF→4'hF (counter disabled) and any jump caused by counter reset, are not wraps.
- On `wrap_det`: `wrap_cnt` <= `wrap_cnt`+1, modulo 16 (4'hF→4'h0, no saturation); `wrap_pulse` <= 1 for exactly one cycle.
- Snapshot value = {`wrap_cnt` + `wrap_det`, `count_in`} — includes a wrap detected in the same cycle, so a capture at count 0 after a wrap carries the new wrap value.
- Push: `capture`=1 and (not `full` or pop this cycle).
- Pop: `snap_valid`=1 and `snap_ready`=1; head advances.
- Push and pop in same cycle: both occur; occupancy unchanged. Allowed when full (push accepted) and any occupancy ≥1.
- Push when full with no pop: dropped; FIFO contents unchanged.
- Empty: `snap_valid`=0; `snap_ready` ignored; `snap_data` don't-care.
- Pointers: log2(`DEPTH`)-bit read/write pointers plus occupancy counter 0..`DEPTH`; pointers wrap naturally.
- `snap_data` is show-ahead: driven from storage at read pointer; FIFO storage itself is not reset.

## Timing
- Reset (synchronous, dominates all inputs): `snap_valid`=0, `full`=0, `wrap_pulse`=0, `wrap_cnt`=0, `ovf`=0, `prev_count`=0, pointers and occupancy 0. A `capture` coincident with reset is discarded.
- Reset mid-operation: all queued snapshots lost; first cycle after reset sees `prev_count`=0, so no false wrap.
- Capture latency: `capture` at edge N → `snap_valid`=1 and `snap_data` updated after edge N (if FIFO was empty).
- Pop latency: `snap_ready` at edge N → next entry (or `snap_valid`=0) after edge N.
- `wrap_det` at edge N → `wrap_cnt` and `wrap_pulse` updated after edge N; `wrap_pulse` falls after edge N+1 unless another wrap (impossible for a +1 counter within 16 cycles).
- `full` and `snap_valid` are registered (derived from occupancy register).

## Configuration
- `SNAP_OVF_EN` defined: `ovf` output port exists; set when a push is dropped (capture while full, no pop); sticky, cleared only by `reset`.
- `SNAP_OVF_EN` undefined: no `ovf` port or logic; dropped captures are silent.

## Test plan
- Reset: `reset`=1 for 2 cycles with `capture`=1 → `snap_valid`=0, `full`=0, `wrap_cnt`=0, `wrap_pulse`=0 after release.
- Wrap: drive `count_in` 4'hE,4'hF,4'h0,4'h1 with `capture` on the 4'h0 cycle → `wrap_pulse` high one cycle, `wrap_cnt`=1, popped `snap_data`=8'h10.
- Wrap-count rollover: 16 full counter cycles → `wrap_cnt` returns to 0; 17th wrap gives 1; holding `count_in`=4'hF for 10 cycles produces no pulse.
- Fill/drain, `DEPTH`=4, `snap_ready`=0: captures at counts 2,3,4,5,6 → `full`=1 after 4th; 5th dropped (`ovf`=1 with `SNAP_OVF_EN`); then `snap_ready`=1 yields 8'h02,8'h03,8'h04,8'h05, then `snap_valid`=0.
- Simultaneous push/pop while full: `capture`=1 and `snap_ready`=1 together → head popped, new entry appended, `full` stays 1, `ovf` unchanged.
- Reset mid-operation: 3 entries queued, `wrap_cnt`=5, assert `reset` one cycle → FIFO empty, `wrap_cnt`=0; next capture at count 4'h7 pops 8'h07.

Source files
------------

// File: rtl/count_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : count_snapshot
// Purpose  : Timestamped event snapshots from a 4-bit free-running counter.
//            Samples the counter every cycle, detects 15->0 wrap-arounds and
//            keeps a 4-bit wrap count so that {wrap_cnt, count} forms an
//            8-bit timestamp. A capture request pushes the timestamp into a
//            small show-ahead FIFO drained through a valid/ready handshake.
//
// Parameters:
//   DEPTH       FIFO entries, power of two, 2..16 (default 4)
//
// Ports:
//   clock       in   1   system clock, rising edge
//   reset       in   1   synchronous active-high reset, clears all state
//   count_in    in   4   counter value (counter_out of the free-running counter)
//   capture     in   1   snapshot request, sampled each rising edge
//   snap_data   out  8   FIFO head {wrap[3:0], count[3:0]}, valid with snap_valid
//   snap_valid  out  1   FIFO non-empty
//   snap_ready  in   1   consumer accepts the head this cycle
//   full        out  1   FIFO holds DEPTH entries
//   wrap_pulse  out  1   one-cycle registered pulse after a detected wrap
//   wrap_cnt    out  4   current wrap count
//   ovf         out  1   sticky dropped-capture flag (only with SNAP_OVF_EN)
//
// Build options:
//   SNAP_OVF_EN  when defined, adds the ovf port and its sticky logic;
//                otherwise captures into a full FIFO are dropped silently.
//
// Revision : 1.0  initial release
// ============================================================================
module count_snapshot #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] count_in,
   input  logic       capture,
   output logic [7:0] snap_data,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic       full,
   output logic       wrap_pulse,
   output logic [3:0] wrap_cnt
`ifdef SNAP_OVF_EN
   ,
   output logic       ovf
`endif
);

   // Pointer width; DEPTH is a power of two so pointers wrap on their own.
   localparam int                 c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]   c_occ_one = (c_ptr_w + 1)'(1);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [3:0]         r_prev_count;
   logic [3:0]         r_wrap_cnt;
   logic               r_wrap_pulse;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_occ;
   logic               r_valid;
   logic               r_full;
   logic [7:0]         r_mem [DEPTH];

   // ------------------------------------------------------------------------
   // Combinational wires
   // ------------------------------------------------------------------------
   logic               w_wrap_det;
   logic [3:0]         w_wrap_nxt;
   logic [7:0]         w_snap;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [c_ptr_w:0]   w_occ_nxt;

   // Only a genuine 15->0 step is a wrap. A held 15 (counter disabled) or a
   // jump to 0 from any other value (counter reset) must not advance the
   // wrap count.
   assign w_wrap_det = (r_prev_count == 4'hF) && (count_in == 4'h0);
   assign w_wrap_nxt = r_wrap_cnt + {3'b000, w_wrap_det};

   // The snapshot uses the post-wrap count so that a capture taken on the
   // very cycle the counter reads 0 after a wrap carries the new epoch.
   assign w_snap = {w_wrap_nxt, count_in};

   // Handshake. A pop frees a slot in the same cycle, so a push into a full
   // FIFO is accepted when the head is leaving.
   assign w_pop  = r_valid && snap_ready;
   assign w_push = capture && (!r_full || w_pop);
   assign w_drop = capture && r_full && !w_pop;

   always_comb begin
      w_occ_nxt = r_occ;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + c_occ_one;
         2'b01:   w_occ_nxt = r_occ - c_occ_one;
         default: w_occ_nxt = r_occ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Counter tracking and wrap count
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         // prev_count restarts at 0 so the first post-reset sample can
         // never look like a 15->0 wrap.
         r_prev_count <= 4'h0;
         r_wrap_cnt   <= 4'h0;
         r_wrap_pulse <= 1'b0;
      end else begin
         r_prev_count <= count_in;
         r_wrap_cnt   <= w_wrap_nxt;
         r_wrap_pulse <= w_wrap_det;
      end
   end

   // ------------------------------------------------------------------------
   // FIFO control: pointers, occupancy and registered status flags
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         r_occ   <= w_occ_nxt;
         r_valid <= (w_occ_nxt != '0);
         r_full  <= (w_occ_nxt == c_depth);
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage: not reset, contents are qualified by snap_valid
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= w_snap;
      end
   end

   // ------------------------------------------------------------------------
   // Optional sticky overflow flag
   // ------------------------------------------------------------------------
`ifdef SNAP_OVF_EN
   logic r_ovf;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
`else
   // Without the overflow option a dropped capture leaves no trace.
   logic w_drop_unused;
   assign w_drop_unused = w_drop;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign snap_data  = r_mem[r_rd_ptr];   // show-ahead head entry
   assign snap_valid = r_valid;
   assign full       = r_full;
   assign wrap_pulse = r_wrap_pulse;
   assign wrap_cnt   = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_count_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_snapshot
// Purpose  : Self-checking bench for count_snapshot. Stimulus drives inputs
//            on the falling edge and updates a timestamp/FIFO reference
//            model; a separate monitor pops expected snapshots whenever the
//            DUT presents an accepted head.
// Revision : 1.0  initial release
// ============================================================================
module tb_count_snapshot;

   localparam int DEPTH = 4;

   logic       clock;
   logic       reset;
   logic [3:0] count_in;
   logic       capture;
   logic [7:0] snap_data;
   logic       snap_valid;
   logic       snap_ready;
   logic       full;
   logic       wrap_pulse;
   logic [3:0] wrap_cnt;
`ifdef SNAP_OVF_EN
   logic       ovf;
`endif

   count_snapshot #(.DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .count_in   (count_in),
      .capture    (capture),
      .snap_data  (snap_data),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .full       (full),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt)
`ifdef SNAP_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: timestamp epoch count and queue of expected snapshots.
   logic [7:0] exp_q[$];
   int         m_wraps;      // total wraps since reset (unbounded)
   int         m_prev;       // last sampled counter value
   bit         m_pulse;      // a wrap occurred at the most recent edge
   bit         m_ovf;
   bit         checks_on;

   int n_checks;
   int n_fail;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check the state left by the previous edge, then drive
   // the inputs for the next edge and advance the model accordingly.
   task automatic cycle(input logic [3:0] cnt, input logic cap,
                        input logic rdy, input logic rst);
      int  occ;
      bit  wrap;
      bit  pop_m;
      logic [3:0] epoch;
      @(negedge clock);
      if (checks_on) begin
         chk("snap_valid", int'(snap_valid), int'(exp_q.size() > 0));
         chk("full",       int'(full),       int'(exp_q.size() == DEPTH));
         chk("wrap_cnt",   int'(wrap_cnt),   m_wraps % 16);
         chk("wrap_pulse", int'(wrap_pulse), int'(m_pulse));
`ifdef SNAP_OVF_EN
         chk("ovf",        int'(ovf),        int'(m_ovf));
`endif
      end
      count_in   = cnt;
      capture    = cap;
      snap_ready = rdy;
      reset      = rst;
      if (rst) begin
         exp_q.delete();
         m_wraps = 0;
         m_prev  = 0;
         m_pulse = 0;
         m_ovf   = 0;
      end else begin
         occ   = exp_q.size();
         wrap  = (m_prev == 15) && (int'(cnt) == 0);
         pop_m = (occ > 0) && rdy;
         epoch = 4'((m_wraps + int'(wrap)) % 16);
         if (cap) begin
            if (occ < DEPTH || pop_m) exp_q.push_back({epoch, cnt});
            else m_ovf = 1;
         end
         if (wrap) m_wraps++;
         m_pulse = wrap;
         m_prev  = int'(cnt);
      end
   endtask

   // Monitor: inputs are stable shortly after the falling edge; an accepted
   // head at the next rising edge must match the oldest expected snapshot.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (checks_on && !reset && snap_valid && snap_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               chk("snap_data", int'(snap_data), int'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   logic [3:0] rc;

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      checks_on  = 0;
      m_wraps    = 0;
      m_prev     = 0;
      m_pulse    = 0;
      m_ovf      = 0;
      reset      = 1'b1;
      count_in   = 4'h0;
      capture    = 1'b1;
      snap_ready = 1'b0;

      // Reset for two cycles with capture held high: must be discarded.
      cycle(4'h3, 1'b1, 1'b0, 1'b1);
      checks_on = 1;
      cycle(4'h4, 1'b1, 1'b1, 1'b1);

      // Wrap: E, F, 0 (captured), 1, then drain.
      cycle(4'hE, 1'b0, 1'b0, 1'b0);
      cycle(4'hF, 1'b0, 1'b0, 1'b0);
      cycle(4'h0, 1'b1, 1'b0, 1'b0);
      cycle(4'h1, 1'b0, 1'b0, 1'b0);
      chk("wrap_snapshot_head", int'(snap_data), 8'h10);
      cycle(4'h2, 1'b0, 1'b1, 1'b0);
      cycle(4'h3, 1'b0, 1'b1, 1'b0);

      // Wrap-count rollover: 17 full counter periods, then hold F.
      cycle(4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 16 * 17; i++) begin
         cycle(4'(i % 16), (i % 16 == 0) && (i >= 16 * 16), 1'b1, 1'b0);
      end
      cycle(4'h1, 1'b0, 1'b1, 1'b0);
      chk("wrap_cnt_17", int'(wrap_cnt), 1);
      for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0, 1'b1, 1'b0);
      cycle(4'h5, 1'b0, 1'b1, 1'b0);

      // Fill/drain: captures at 2..6 with ready low, fifth is dropped.
      cycle(4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 2; i <= 6; i++) cycle(4'(i), 1'b1, 1'b0, 1'b0);
      cycle(4'h7, 1'b0, 1'b0, 1'b0);
      chk("fill_full", int'(full), 1);
      // Simultaneous push and pop while full.
      cycle(4'h8, 1'b1, 1'b1, 1'b0);
      cycle(4'h9, 1'b0, 1'b0, 1'b0);
      chk("pushpop_full", int'(full), 1);
      for (int i = 0; i < DEPTH + 1; i++) cycle(4'hA, 1'b0, 1'b1, 1'b0);

      // Reset mid-operation: five wraps, three queued entries, then reset.
      cycle(4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 16 * 5 + 3; i++) begin
         cycle(4'(i % 16), (i > 16 * 5), 1'b0, 1'b0);
      end
      chk("pre_reset_wraps", int'(wrap_cnt), 5);
      cycle(4'h4, 1'b0, 1'b0, 1'b1);
      cycle(4'h7, 1'b1, 1'b0, 1'b0);
      cycle(4'h8, 1'b0, 1'b0, 1'b0);
      chk("post_reset_head", int'(snap_data), 8'h07);
      cycle(4'h9, 1'b0, 1'b1, 1'b0);

      // Randomized phase: mostly counting, occasional stalls and jumps.
      rc = 4'h9;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(63) == 0) rc = 4'($urandom_range(15));
         else if ($urandom_range(7) != 0) rc = rc + 4'h1;
         cycle(rc, ($urandom_range(2) == 0), ($urandom_range(1) == 0),
               ($urandom_range(299) == 0));
      end

      // Drain whatever remains, with a bounded cycle budget.
      for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) begin
         rc = rc + 4'h1;
         cycle(rc, 1'b0, 1'b1, 1'b0);
      end
      cycle(rc, 1'b0, 1'b0, 1'b0);
      chk("drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
